cpu_reg_wb_ctrl: RTL

CPU_REG_WB_CTRL -- requirements
Module: cpu_reg_wb_ctrl

---
 rtl/cpu_reg_pkg.sv | 10 +
 rtl/cpu_rr_arbiter.sv | 20 ++
 rtl/cpu_reg_wb_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg: shared widths, write-back requester ids and round-robin successor helper
package cpu_reg_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_WB_REQ = 3;
  typedef enum logic [1:0] {WB_ALU, WB_LSU, WB_CSR} wb_req_e;
  function automatic wb_req_e rr_next(wb_req_e i);
    return i == WB_CSR ? WB_ALU : wb_req_e'(i + 2'd1);
  endfunction
endpackage

// File: rtl/cpu_rr_arbiter.sv
// cpu_rr_arbiter: 3-way round-robin grant starting at pointer p, p moves past each winner
module cpu_rr_arbiter
  import cpu_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WB_REQ-1:0] req,
  output logic [NUM_WB_REQ-1:0] gnt,
  output wb_req_e               gnt_idx
);
  wb_req_e p, c1, c2;
  always_comb begin
    c1 = rr_next(p);
    c2 = rr_next(c1);
    gnt_idx = req[p] ? p : req[c1] ? c1 : c2;
    gnt = rst || !(|req) ? '0 : NUM_WB_REQ'(1) << gnt_idx;
  end
  always_ff @(posedge clk)
    p <= rst ? WB_ALU : |gnt ? rr_next(gnt_idx) : p;
endmodule

// File: rtl/cpu_reg_wb_ctrl.sv
// cpu_reg_wb_ctrl: write-back arbitration, register-file write and busy scoreboard (CPU_REG_WB_BYPASS_EN adds bypass ports)
module cpu_reg_wb_ctrl
  import cpu_reg_pkg::*;
#(
  parameter int MORE_REGISTERS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_WB_REQ-1:0]                 wb_valid,
  output logic [NUM_WB_REQ-1:0]                 wb_ready,
  input  logic [NUM_WB_REQ-1:0][REG_ADDR_W-1:0] wb_addr,
  input  logic [NUM_WB_REQ-1:0][DATA_W-1:0]     wb_data,
  input  logic                                  iss_valid,
  input  logic [REG_ADDR_W-1:0]                 iss_addr,
  output logic                                  iss_ready,
  input  logic [REG_ADDR_W-1:0]                 chk_addr1,
  input  logic [REG_ADDR_W-1:0]                 chk_addr2,
  output logic                                  chk_busy1,
  output logic                                  chk_busy2,
  output logic [REG_ADDR_W-1:0]                 rf_addr_wr,
  output logic [DATA_W-1:0]                     rf_data_wr,
  output logic                                  rf_wr,
  output logic                                  wr_illegal
`ifdef CPU_REG_WB_BYPASS_EN
  ,
  output logic                                  byp_hit1,
  output logic                                  byp_hit2,
  output logic [DATA_W-1:0]                     byp_data
`endif
);
  localparam int NREG = 2 ** REG_ADDR_W;
  function automatic logic in_range(logic [REG_ADDR_W-1:0] a);
    return MORE_REGISTERS != 0 || !a[REG_ADDR_W-1];
  endfunction
  wb_req_e g;
  logic [REG_ADDR_W-1:0] ga;
  logic [DATA_W-1:0] gd;
  logic [NREG-1:0] busy, set_m, clr_m;
  logic hit1, hit2;
  cpu_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (wb_valid),
    .gnt    (wb_ready),
    .gnt_idx(g)
  );
  always_comb begin
    ga = wb_addr[g];
    gd = wb_data[g];
    iss_ready = !busy[iss_addr];
    set_m = iss_valid && iss_ready && iss_addr != '0 && in_range(iss_addr) ? NREG'(1) << iss_addr : '0;
    clr_m = rf_wr ? NREG'(1) << rf_addr_wr : '0;
`ifdef CPU_REG_WB_BYPASS_EN
    hit1 = rf_wr && rf_addr_wr == chk_addr1 && chk_addr1 != '0;
    hit2 = rf_wr && rf_addr_wr == chk_addr2 && chk_addr2 != '0;
`else
    hit1 = 1'b0;
    hit2 = 1'b0;
`endif
    chk_busy1 = busy[chk_addr1] && !hit1;
    chk_busy2 = busy[chk_addr2] && !hit2;
  end
`ifdef CPU_REG_WB_BYPASS_EN
  assign byp_hit1 = hit1;
  assign byp_hit2 = hit2;
  assign byp_data = rf_data_wr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      rf_wr <= 1'b0;
      wr_illegal <= 1'b0;
      rf_addr_wr <= '0;
      rf_data_wr <= '0;
    end else begin
      busy <= (busy & ~clr_m) | set_m;
      rf_wr <= |wb_ready && ga != '0 && in_range(ga);
      wr_illegal <= |wb_ready && !in_range(ga);
      rf_addr_wr <= |wb_ready ? ga : rf_addr_wr;
      rf_data_wr <= |wb_ready ? gd : rf_data_wr;
    end
  end
endmodule
